// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-port responder for the rv32i_cpu core.
// Decodes each access into a word-addressed RAM or a 32-byte MMIO register block:
//   0x00 TOHOST, 0x04 CONSOLE_TX, 0x08 STATUS, 0x0C CYCLE_LO, 0x10 CYCLE_HI, 0x14-0x1C reserved.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   data_addr       byte address; bits [1:0] ignored
//   data_wdata      write data
//   data_we         byte-lane write enables
//   data_re         read strobe
//   data_rdata      combinational read data, zero when data_re=0
//   con_valid/con_data/con_ready  console TX FIFO drain port
//   halt/halt_code  sticky halt flag and tohost>>1 exit code
//   bus_err         sticky unmapped-access flag
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  input  logic        data_re,
  output logic [31:0] data_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt,
  output logic [30:0] halt_code,
  output logic        bus_err
);

  localparam int unsigned RamAw    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RamBytes = 33'(RAM_WORDS) * 33'd4;
  localparam logic [32:0] MmioEnd  = {1'b0, MMIO_BASE} + 33'd32;
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]      word_addr;
  logic             ram_hit;
  logic             mmio_hit;
  logic             unmapped;
  logic [2:0]       reg_sel;
  logic [RamAw-1:0] ram_idx;
  logic             wr_any;
  logic             unused_addr_lsb;

  assign word_addr       = {data_addr[31:2], 2'b00};
  assign unused_addr_lsb = ^data_addr[1:0];
  assign ram_hit         = {1'b0, word_addr} < RamBytes;
  assign mmio_hit        = (word_addr >= MMIO_BASE) && ({1'b0, word_addr} < MmioEnd);
  assign unmapped        = !ram_hit && !mmio_hit;
  // Low address bits are zero on both sides, so the 5-bit difference is the exact offset
  // even when MMIO_BASE is not 32-byte aligned.
  assign reg_sel         = word_addr[4:2] - MMIO_BASE[4:2];
  assign ram_idx         = data_addr[RamAw+1:2];
  assign wr_any          = |data_we;

  logic tohost_wr;
  logic con_push;
  logic status_wr;
  logic lo_rd;

  assign tohost_wr = mmio_hit && (reg_sel == 3'd0) && wr_any;
  assign con_push  = mmio_hit && (reg_sel == 3'd1) && data_we[0];
  assign status_wr = mmio_hit && (reg_sel == 3'd2) && data_we[0];
  assign lo_rd     = mmio_hit && (reg_sel == 3'd3) && data_re;

  // ---------------------------------------------------------------------------
  // RAM: not reset so a bench preload survives rst; writes blocked during rst
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (!rst && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_we[i]) ram[ram_idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Console TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FifoFull);
  assign pop     = !empty && con_ready;
  // A full FIFO still takes the byte when a pop frees a slot at the same edge.
  assign push_ok = con_push && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr_q] <= data_wdata[7:0];
  end

  assign con_valid = !empty;
  assign con_data  = fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Register block next state
  // ---------------------------------------------------------------------------
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q, halt_d;
  logic [30:0] halt_code_q, halt_code_d;
  logic        bus_err_q, bus_err_d;
  logic        ovf_q, ovf_d;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;

  always_comb begin
    tohost_d    = tohost_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    bus_err_d   = bus_err_q;
    ovf_d       = ovf_q;
    cyc_d       = cyc_q + 64'd1;
    hi_shadow_d = hi_shadow_q;

    // Once halted the tohost register is frozen so the exit code cannot be overwritten.
    if (tohost_wr && !halt_q) begin
      tohost_d = data_wdata;
      if (data_wdata[0]) begin
        halt_d      = 1'b1;
        halt_code_d = data_wdata[31:1];
      end
    end

    if (con_push && full && !pop) ovf_d = 1'b1;

    if (status_wr) begin
      if (data_wdata[2]) ovf_d     = 1'b0;
      if (data_wdata[3]) bus_err_d = 1'b0;
    end

    if (unmapped && (data_re || wr_any)) bus_err_d = 1'b1;

    // Latch the upper half on a LO read so a later HI read pairs coherently.
    if (lo_rd) hi_shadow_d = cyc_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_q    <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      bus_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      cyc_q       <= '0;
      hi_shadow_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      tohost_q    <= tohost_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      bus_err_q   <= bus_err_d;
      ovf_q       <= ovf_d;
      cyc_q       <= cyc_d;
      hi_shadow_q <= hi_shadow_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign bus_err   = bus_err_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    data_rdata = '0;
    if (data_re) begin
      if (ram_hit) begin
        data_rdata = ram[ram_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          3'd0:    data_rdata = tohost_q;
          3'd1:    data_rdata = {24'b0, con_data};
          3'd2:    data_rdata = {28'b0, bus_err_q, ovf_q, full, empty};
          3'd3:    data_rdata = cyc_q[31:0];
          3'd4:    data_rdata = hi_shadow_q;
          default: data_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] Base = 32'h1000_0000;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic        data_re;
  logic [31:0] data_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        halt;
  logic [30:0] halt_code;
  logic        bus_err;

  dmem_mmio_responder #(
    .RAM_WORDS (4096),
    .MMIO_BASE (Base),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_we   (data_we),
    .data_re   (data_re),
    .data_rdata(data_rdata),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .halt      (halt),
    .halt_code (halt_code),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_ram [32];
  logic [7:0]  m_fifo [$];
  logic        m_halt;
  logic [30:0] m_code;
  logic [31:0] m_tohost;
  logic        m_bus;
  logic        m_ovf;
  logic [63:0] m_cyc;
  logic [31:0] m_hi;

  logic [31:0] obs_rdata;
  logic        obs_valid;
  logic [7:0]  obs_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_halt = 0; m_code = '0; m_tohost = '0; m_bus = 0; m_ovf = 0; m_cyc = '0; m_hi = '0;
  endtask

  task automatic model_read(input logic [31:0] a, input logic re,
                            output logic [31:0] exp, output logic chk);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    exp = 0;
    chk = 1;
    if (!re) return;
    if (w < 32'd16384) begin
      if (w < 32'd128) exp = m_ram[w[6:2]];
      else chk = 0;
    end else if (w >= Base && w < Base + 32) begin
      case ((w - Base) >> 2)
        0: exp = m_tohost;
        1: if (m_fifo.size() != 0) exp = {24'b0, m_fifo[0]}; else chk = 0;
        2: exp = {28'b0, m_bus, m_ovf, m_fifo.size() == Depth, m_fifo.size() == 0};
        3: exp = m_cyc[31:0];
        4: exp = m_hi;
        default: exp = 0;
      endcase
    end
  endtask

  task automatic model_update(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                              input logic re, input logic rdy, input logic r);
    logic [31:0] w;
    bit          is_ram, is_mmio, pop, was_full;
    int          off;
    if (r) begin
      model_reset();
      return;
    end
    w        = a & 32'hFFFF_FFFC;
    is_ram   = w < 32'd16384;
    is_mmio  = w >= Base && w < Base + 32;
    off      = int'((w - Base) >> 2);
    pop      = m_fifo.size() != 0 && rdy;
    was_full = m_fifo.size() == Depth;
    if (is_ram && w < 32'd128) begin
      for (int i = 0; i < 4; i++) if (we[i]) m_ram[w[6:2]][8*i +: 8] = wd[8*i +: 8];
    end
    if (is_mmio) begin
      if (off == 0 && we != 0 && !m_halt) begin
        m_tohost = wd;
        if (wd[0]) begin m_halt = 1; m_code = wd[31:1]; end
      end
      if (off == 2 && we[0]) begin
        if (wd[2]) m_ovf = 0;
        if (wd[3]) m_bus = 0;
      end
      if (off == 3 && re) m_hi = m_cyc[63:32];
    end
    if (!is_ram && !is_mmio && (re || we != 0)) m_bus = 1;
    if (pop) void'(m_fifo.pop_front());
    if (is_mmio && off == 1 && we[0]) begin
      if (!was_full || pop) m_fifo.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    m_cyc = m_cyc + 64'd1;
  endtask

  // Called at a negedge: drive, check combinational outputs, clock, advance the model.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                      input logic re, input logic rdy, input logic r);
    logic [31:0] exp;
    logic        chk;
    data_addr = a; data_wdata = wd; data_we = we; data_re = re; con_ready = rdy; rst = r;
    #1;
    model_read(a, re, exp, chk);
    obs_rdata = data_rdata;
    obs_valid = con_valid;
    obs_data  = con_data;
    if (chk) check("rdata", data_rdata, exp);
    check("con_valid", con_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) check("con_data", con_data, m_fifo[0]);
    check("halt", halt, m_halt);
    check("halt_code", halt_code, m_code);
    check("bus_err", bus_err, m_bus);
    @(posedge clk);
    model_update(a, wd, we, re, rdy, r);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(32'h0, 32'h0, 4'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] ra;
  logic [7:0]  got_bytes [Depth];
  int          sel;

  initial begin
    rst = 1; data_addr = 0; data_wdata = 0; data_we = 0; data_re = 0; con_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();

    // Reset state
    check("rst_con_valid", con_valid, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    step(Base + 8, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("rst_status", obs_rdata, 32'h1);

    // Preload RAM words 0..31
    for (int i = 0; i < 32; i++) step(32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 1'b0);

    // RAM byte lanes
    step(32'h40, 32'hAABB_CCDD, 4'hF, 1'b0, 1'b0, 1'b0);
    step(32'h40, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 1'b0);
    step(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("ram_lanes", obs_rdata, 32'hAA22_CC44);
    step(32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("ram_re0", obs_rdata, 32'h0);
    // Read-during-write returns the old word
    step(32'h44, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(32'h44, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0);
    check("ram_rdw_old", obs_rdata, 32'h0);

    // Tohost
    step(Base, 32'h1, 4'hF, 1'b0, 1'b0, 1'b0);
    check("tohost_pass_halt", halt, 1'b1);
    check("tohost_pass_code", halt_code, 31'd0);
    do_reset();
    step(Base, 32'h2B, 4'hF, 1'b0, 1'b0, 1'b0);
    check("tohost_fail_halt", halt, 1'b1);
    check("tohost_fail_code", halt_code, 31'd21);
    step(Base, 32'h1, 4'hF, 1'b0, 1'b0, 1'b0);
    check("tohost_sticky_code", halt_code, 31'd21);
    step(Base, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("tohost_read", obs_rdata, 32'h2B);

    // Console overflow and drain
    do_reset();
    for (int i = 0; i < 9; i++) step(Base + 4, 32'h41 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0);
    step(Base + 8, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("fifo_status_full_ovf", obs_rdata, 32'h6);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("drain_valid", obs_valid, 1'b1);
      check("drain_data", obs_data, 8'h41 + 8'(i));
    end
    step(Base + 8, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("drained_valid", obs_valid, 1'b0);
    check("drained_status", obs_rdata, 32'h5);
    step(Base + 8, 32'h4, 4'h1, 1'b0, 1'b0, 1'b0);
    step(Base + 8, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("ovf_cleared", obs_rdata, 32'h1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(Base + 4, 32'h41 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0);
    step(Base + 4, 32'h5A, 4'h1, 1'b0, 1'b1, 1'b0);
    check("full_pushpop_head", obs_data, 8'h41);
    step(Base + 8, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("full_pushpop_status", obs_rdata, 32'h2);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      got_bytes[i] = obs_data;
    end
    check("full_pushpop_first", got_bytes[0], 8'h42);
    check("full_pushpop_z8", got_bytes[7], 8'h5A);

    // Cycle counter coherence
    dut.cyc_q = 64'h0000_0001_FFFF_FFFE;
    m_cyc     = 64'h0000_0001_FFFF_FFFE;
    step(Base + 12, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("cyc_lo", obs_rdata, 32'hFFFF_FFFE);
    idle(1'b0);
    step(Base + 16, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("cyc_hi_coherent", obs_rdata, 32'h1);
    dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cyc     = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(1'b0);
    step(Base + 12, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("cyc_wrap", obs_rdata, 32'h0);
    do_reset();
    step(Base + 12, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("cyc_reset", obs_rdata, 32'h0);

    // Unmapped access and mid-operation reset
    step(32'h2000_0000, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("unmapped_rdata", obs_rdata, 32'h0);
    check("unmapped_bus_err", bus_err, 1'b1);
    for (int i = 0; i < 3; i++) step(Base + 4, 32'h61 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0);
    check("queued_valid", con_valid, 1'b1);
    do_reset();
    check("rst_mid_valid", con_valid, 1'b0);
    check("rst_mid_bus_err", bus_err, 1'b0);
    step(32'h40, 0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("ram_survives_rst", obs_rdata, 32'hAA22_CC44);
    step(32'h0000_4000, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("unmapped_idle_no_err", bus_err, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        ra = {25'b0, 5'($urandom_range(0, 31)), 2'($urandom)};
      end else if (sel < 9) begin
        ra = Base + 32'($urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 3))
          0: ra = 32'h2000_0000;
          1: ra = 32'h0000_4000;
          2: ra = Base + 32;
          default: ra = Base - 4;
        endcase
      end
      step(ra, $urandom, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
           1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder for the rv32i_cpu data port. Decodes each access into a word-addressed RAM region or a small MMIO register block: a tohost halt register, a console TX FIFO with a valid/ready drain port, and a coherent 64-bit cycle counter. It replaces the data half of simple_memory in benches and FPGA tops, so programs can end with a pass/fail code instead of relying on a system-instruction halt.

## Interface
- RAM_WORDS, 4096: RAM depth in 32-bit words; RAM spans byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h1000_0000: base byte address of the register block, which spans 32 bytes.
- FIFO_DEPTH, 8: console TX FIFO entries, a power of two and at least 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- data_addr  in  32  byte address from the CPU; bits [1:0] are ignored.
- data_wdata  in  32  write data.
- data_we  in  4  byte-lane write enables; lane i maps to bits [8i+7:8i].
- data_re  in  1  read strobe.
- data_rdata  out  32  read data, combinational.
- con_valid  out  1  console byte available.
- con_data  out  8  head byte of the console FIFO.
- con_ready  in  1  console sink accepts the byte.
- halt  out  1  sticky; the program has written tohost.
- halt_code  out  31  the tohost value shifted right by 1; 0 means pass.
- bus_err  out  1  sticky; an access fell outside both regions.

## Operation
- Decode uses the word address. The RAM region is addr < RAM_WORDS*4. The MMIO region is MMIO_BASE <= addr < MMIO_BASE+32. Every other address is unmapped.
- RAM:
  - Each lane with data_we[i]=1 is written at posedge.
  - The read returns the array word at that address.
  - RAM contents are not reset, so bench preload via $readmemh into the array "ram" survives rst.
- MMIO registers, by byte offset:
  - 0x00 TOHOST:
    - A write with data_we!=0 stores the full data_wdata into tohost_q.
    - If data_wdata[0]=1 and halt=0, halt is set and halt_code is set to data_wdata[31:1].
    - Once halt=1, further TOHOST writes are ignored entirely.
    - A read returns tohost_q.
  - 0x04 CONSOLE_TX:
    - A write with data_we[0]=1 pushes data_wdata[7:0].
    - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and ovf is set.
    - A read returns {24'b0, con_data}.
  - 0x08 STATUS:
    - A read returns {28'b0, bus_err, ovf, full, empty}.
    - A write with data_we[0]=1 and data_wdata[2]=1 clears ovf.
    - Writing data_wdata[3]=1 clears bus_err.
  - 0x0C CYCLE_LO:
    - A read returns cyc[31:0].
    - A read with data_re=1 also captures cyc[63:32] into hi_shadow at that posedge.
  - 0x10 CYCLE_HI: a read returns hi_shadow. Writes have no effect.
  - 0x14–0x1C: reads return 0; writes are ignored.
- Unmapped addresses:
  - The read returns 0 and writes are ignored.
  - An access with data_re=1 or data_we!=0 sets bus_err.
  - An idle unmapped address with data_re=0 and we=0 does not set bus_err.
- Read data gating: data_rdata=0 whenever data_re=0.
- cyc:
  - 64-bit counter that increments every non-reset cycle.
  - It wraps from 2^64-1 to 0.
  - It keeps counting after halt.
- Console FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
  - con_valid = !empty and con_data = mem[rd_ptr].
  - A pop occurs when con_valid && con_ready.
  - When the FIFO is full, a push in the same cycle as a pop is accepted and the count stays unchanged.
  - A push and pop in the same cycle when the FIFO is empty is not possible; the push is accepted and con_valid rises the next cycle. There is no fall-through.
- con_data must hold stable while con_valid=1 and con_ready=0.

## Timing
- Reads are combinational, with zero latency in the same cycle, matching the CPU single-cycle data port.
- Writes, FIFO pushes and pops, and all register updates take effect at the posedge where they are asserted.
- A read in the same cycle as a write to the same RAM word returns the old word.
- A FIFO push is visible on con_valid one cycle after the write.
- Reset values:
  - data_rdata=0 while data_re=0.
  - con_valid=0.
  - con_data is don't-care but must be non-X after the first push.
  - halt=0, halt_code=0, bus_err=0.
  - Internal: ovf=0, tohost_q=0, cyc=0, hi_shadow=0, FIFO pointers and count = 0.
- Reset mid-operation, including while the FIFO is non-empty or con_valid=1 with con_ready=0:
  - All FIFO contents are discarded and con_valid drops the cycle after the rst posedge.
  - RAM is untouched.
- Reset has priority over any simultaneous write or pop.

## Test plan
- RAM byte lanes: write 32'hAABBCCDD with we=4'hF to addr 0x40, then write 32'h11223344 with we=4'b0101 -> a read of 0x40 returns 32'hAA22CC44. A read of 0x40 with data_re=0 returns 0.
- Tohost pass/fail:
  - Write 1 to MMIO_BASE -> next cycle halt=1 and halt_code=0.
  - After reset, write 32'h0000_002B -> halt=1 and halt_code=21.
  - A later write of 1 leaves halt_code=21 and a read returns 32'h2B.
- Console FIFO, depth 8:
  - With con_ready=0, push 'A'..'I' (9 writes) -> STATUS reads 0b0110 (full=1, ovf=1, empty=0).
  - Raise con_ready -> con_data presents 'A'..'H' over 8 cycles, then con_valid=0 and STATUS reads 0b0101.
  - Write 0x4 to STATUS -> reads 0b0001.
- Full with simultaneous push and pop: fill 8 entries, then in the same cycle push 'Z' with con_ready=1 -> count stays 8, 'A' pops, and 'Z' emerges 8th.
- Cycle counter coherence:
  - Backdoor-force cyc=64'h0000_0001_FFFF_FFFE, read LO, then read HI two cycles later -> LO=32'hFFFF_FFFE and HI=1, not 2.
  - Reset -> cyc=0.
- Unmapped and reset: read 0x2000_0000 -> 0 and bus_err=1. Assert rst for 1 cycle with 3 bytes queued -> con_valid=0, bus_err=0, and RAM word 0x40 is still intact.
